// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit_pkg: shared types and constants for the fetch stage        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package fetch_unit_pkg;

  // ysyx_23060251 pc_bus / inst_bus widths
  localparam int PC_BUS_W   = 32;
  localparam int INST_BUS_W = 32;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_RESP  = 3'd1,
    S_OUT   = 3'd2,
    S_WAIT  = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_e;

  localparam logic [1:0] FETCH_FAULT_NONE     = 2'b00;
  localparam logic [1:0] FETCH_FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FETCH_FAULT_BUSERR   = 2'b10;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit: multi-cycle handshaked instruction fetch, owns the PC     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               XLEN           = PC_BUS_W,
  parameter logic [XLEN-1:0]  RESET_PC       = XLEN'(DEFAULT_RESET_PC),
  // Counter value loaded on reset; nonzero only to exercise the wrap.
  parameter logic [31:0]      FETCH_CNT_INIT = 32'h0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [XLEN-1:0] araddr_o,
  output logic            arvalid_o,
  input  logic            arready_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      rresp_i,
  input  logic            rvalid_i,
  output logic            rready_o,
  output logic [XLEN-1:0] inst_o,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] pc_o,
  input  logic            npc_valid_i,
  input  logic [XLEN-1:0] npc_i,
  output logic            fault_o,
  output logic [1:0]      fault_cause_o,
  output logic [31:0]     fetch_cnt_o
);

  fetch_state_e state;

  // Handshake outputs are pure state decodes so they never depend on inputs.
  assign arvalid_o    = (state == S_REQ);
  assign rready_o     = (state == S_RESP);
  assign inst_valid_o = (state == S_OUT);
  assign araddr_o     = pc_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_REQ;
      pc_o          <= RESET_PC;
      inst_o        <= '0;
      fault_o       <= 1'b0;
      fault_cause_o <= FETCH_FAULT_NONE;
      fetch_cnt_o   <= FETCH_CNT_INIT;
    end else begin
      case (state)
        S_REQ: begin
          if (arready_i) state <= S_RESP;
        end
        S_RESP: begin
          if (rvalid_i) begin
            if (rresp_i == RESP_OKAY) begin
              inst_o <= rdata_i;
              state  <= S_OUT;
            end else begin
              fault_o       <= 1'b1;
              fault_cause_o <= FETCH_FAULT_BUSERR;
              state         <= S_FAULT;
            end
          end
        end
        S_OUT: begin
          if (inst_ready_i) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (npc_valid_i) begin
            if (npc_i[1:0] != 2'b00) begin
              fault_o       <= 1'b1;
              fault_cause_o <= FETCH_FAULT_MISALIGN;
              state         <= S_FAULT;
            end else begin
              pc_o  <= npc_i;
              state <= S_REQ;
            end
          end
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state <= S_FAULT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_unit: directed stimulus, per-cycle compare against a model   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        inst_ready = 1'b0;
  logic        npc_valid = 1'b0;
  logic [31:0] npc = '0;

  logic [31:0] araddr, inst, pc, cnt;
  logic        arvalid, rready, inst_valid, fault;
  logic [1:0]  cause;

  logic [31:0] w_araddr, w_inst, w_pc, w_cnt;
  logic        w_arvalid, w_rready, w_inst_valid, w_fault;
  logic [1:0]  w_cause;

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i(clk), .rst_i(rst),
    .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(rready),
    .inst_o(inst), .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
    .pc_o(pc), .npc_valid_i(npc_valid), .npc_i(npc),
    .fault_o(fault), .fault_cause_o(cause), .fetch_cnt_o(cnt)
  );

  // Second copy whose counter starts one below the wrap point.
  fetch_unit #(.FETCH_CNT_INIT(32'hFFFF_FFFF)) dut_w (
    .clk_i(clk), .rst_i(rst),
    .araddr_o(w_araddr), .arvalid_o(w_arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_o(w_rready),
    .inst_o(w_inst), .inst_valid_o(w_inst_valid), .inst_ready_i(inst_ready),
    .pc_o(w_pc), .npc_valid_i(npc_valid), .npc_i(npc),
    .fault_o(w_fault), .fault_cause_o(w_cause), .fetch_cnt_o(w_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: what the unit is waiting for next.
  typedef enum int {M_ADDR, M_DATA, M_HANDOFF, M_NEXTPC, M_DEAD} phase_t;
  phase_t      ph;
  logic [31:0] m_pc, m_inst, m_cnt;
  logic        m_fault;
  logic [1:0]  m_cause;

  always @(posedge clk) begin
    if (rst) begin
      ph = M_ADDR; m_pc = 32'h8000_0000; m_inst = 0; m_cnt = 0;
      m_fault = 0; m_cause = 2'b00;
    end else begin
      if (npc_valid && ph != M_NEXTPC) begin
        errors++;
        $display("FAIL protocol: npc_valid asserted outside next-PC wait at %0t", $time);
      end
      case (ph)
        M_ADDR:    if (arready) ph = M_DATA;
        M_DATA:    if (rvalid) begin
                     if (rresp == 2'b00) begin m_inst = rdata; ph = M_HANDOFF; end
                     else begin m_fault = 1; m_cause = 2'b10; ph = M_DEAD; end
                   end
        M_HANDOFF: if (inst_ready) begin m_cnt = m_cnt + 1; ph = M_NEXTPC; end
        M_NEXTPC:  if (npc_valid) begin
                     if (npc % 4 != 0) begin m_fault = 1; m_cause = 2'b01; ph = M_DEAD; end
                     else begin m_pc = npc; ph = M_ADDR; end
                   end
        default:   ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("arvalid", arvalid, ph == M_ADDR);
      chk("rready", rready, ph == M_DATA);
      chk("inst_valid", inst_valid, ph == M_HANDOFF);
      chk("araddr", araddr, m_pc);
      chk("pc", pc, m_pc);
      chk("inst", inst, m_inst);
      chk("fault", fault, m_fault);
      chk("cause", cause, m_cause);
      chk("cnt", cnt, m_cnt);
      chk("w_arvalid", w_arvalid, ph == M_ADDR);
      chk("w_rready", w_rready, ph == M_DATA);
      chk("w_inst_valid", w_inst_valid, ph == M_HANDOFF);
      chk("w_araddr", w_araddr, m_pc);
      chk("w_pc", w_pc, m_pc);
      chk("w_inst", w_inst, m_inst);
      chk("w_fault", w_fault, m_fault);
      chk("w_cause", w_cause, m_cause);
      chk("w_cnt", w_cnt, m_cnt + 32'hFFFF_FFFF);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset and state at cycle t (S_REQ)
    tick();
    armed = 1'b1;
    do_reset();
    chk("rst_arvalid", arvalid, 1);
    chk("rst_rready", rready, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_araddr", araddr, 32'h8000_0000);
    chk("rst_inst", inst, 0);
    chk("rst_fault", {30'b0, cause} | {31'b0, fault}, 0);
    chk("rst_cnt", cnt, 0);

    // Basic fetch: accept at t, data at t+1, valid at t+2
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0013; rresp = 2'b00;
    tick();
    rvalid = 1'b0;
    chk("basic_inst_valid", inst_valid, 1);
    chk("basic_inst", inst, 32'h0000_0013);

    // Decoder back-pressure
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_inst_valid", inst_valid, 1);
      chk("bp_inst", inst, 32'h0000_0013);
      chk("bp_arvalid", arvalid, 0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("bp_cnt", cnt, 1);
    chk("bp_wrap_cnt", w_cnt, 0);

    // Next-PC redirect and memory stall
    npc_valid = 1'b1; npc = 32'h8000_0004;
    tick();
    npc_valid = 1'b0;
    chk("npc_arvalid", arvalid, 1);
    chk("npc_araddr", araddr, 32'h8000_0004);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_araddr", araddr, 32'h8000_0004);
      chk("stall_arvalid", arvalid, 1);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0010_0093;
    tick();
    rvalid = 1'b0; inst_ready = 1'b1;
    chk("fetch2_inst", inst, 32'h0010_0093);
    tick();
    inst_ready = 1'b0;
    chk("fetch2_cnt", cnt, 2);

    // Misaligned next PC
    npc_valid = 1'b1; npc = 32'h8000_0006;
    tick();
    npc_valid = 1'b0;
    chk("mis_fault", fault, 1);
    chk("mis_cause", cause, 2'b01);
    chk("mis_pc", pc, 32'h8000_0004);
    arready = 1'b1; rvalid = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mis_arvalid", arvalid, 0);
      chk("mis_rready", rready, 0);
    end
    arready = 1'b0; rvalid = 1'b0; inst_ready = 1'b0;

    // Bus error
    do_reset();
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
    tick();
    rvalid = 1'b0; rresp = 2'b00; inst_ready = 1'b1;
    chk("berr_fault", fault, 1);
    chk("berr_cause", cause, 2'b10);
    chk("berr_inst", inst, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("berr_inst_valid", inst_valid, 0);
    end
    inst_ready = 1'b0;

    // Reset mid-read, late data ignored
    do_reset();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("mid_rready", rready, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678;
    chk("mid_pc", pc, 32'h8000_0000);
    chk("mid_arvalid", arvalid, 1);
    chk("mid_rready0", rready, 0);
    tick();
    rvalid = 1'b0;
    chk("late_arvalid", arvalid, 1);
    chk("late_inst", inst, 0);
    chk("late_cnt", cnt, 0);

    // One fetch with the preloaded counter wraps to zero
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0073;
    tick();
    rvalid = 1'b0; inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("wrap_cnt", w_cnt, 0);
    chk("wrap_ref_cnt", cnt, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Multi-cycle instruction fetch stage. It replaces the combinational PC-to-instruction path with a handshaked read bus to instruction memory. It owns the architectural PC and issues one read per instruction. Each fetched instruction is presented to the decoder under valid/ready, and the unit then waits for the execute stage to return the next PC before fetching again.

## Interface
Parameters:
- XLEN, 32, width of PC, address and instruction.
- RESET_PC, 32'h8000_0000, PC loaded on reset.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- araddr_o  out  XLEN  read address, equals pc_o.
- arvalid_o  out  1  read request valid.
- arready_i  in  1  memory accepts the request.
- rdata_i  in  XLEN  read data.
- rresp_i  in  2  read response; 2'b00 is OKAY, anything else is an error.
- rvalid_i  in  1  read data valid.
- rready_o  out  1  unit accepts read data.
- inst_o  out  XLEN  fetched instruction to the decoder.
- inst_valid_o  out  1  inst_o valid.
- inst_ready_i  in  1  decoder consumes inst_o.
- pc_o  out  XLEN  PC of the current or most recently fetched instruction.
- npc_valid_i  in  1  execute stage presents the next PC.
- npc_i  in  XLEN  next PC.
- fault_o  out  1  sticky fetch fault.
- fault_cause_o  out  2  fault cause: 01 misaligned PC, 10 bus error, 00 none.
- fetch_cnt_o  out  32  count of instructions handed to the decoder.

## Operation
- States: S_REQ, S_RESP, S_OUT, S_WAIT, S_FAULT. All outputs are registers or pure decodes of the state.
- Reset values:
  - state=S_REQ, pc_o=RESET_PC, inst_o=0, fault_o=0, fault_cause_o=00, fetch_cnt_o=0.
  - State decodes: arvalid_o=1, rready_o=0, inst_valid_o=0.
- S_REQ: arvalid_o=1, araddr_o=pc_o.
  - arvalid_o and araddr_o stay stable until arready_i is sampled high.
  - On arready_i=1, go to S_RESP.
- S_RESP: rready_o=1.
  - On rvalid_i=1 and rresp_i=00: inst_o<=rdata_i, go to S_OUT.
  - On rvalid_i=1 and rresp_i!=00: fault_cause_o<=10, fault_o<=1, go to S_FAULT. inst_o is unchanged.
- S_OUT: inst_valid_o=1; inst_o is held stable.
  - On inst_ready_i=1: fetch_cnt_o increments by 1, wrapping modulo 2^32, and the unit goes to S_WAIT.
- S_WAIT: waits for npc_valid_i.
  - If npc_i[1:0]!=0: fault_cause_o<=01, fault_o<=1, go to S_FAULT. pc_o keeps the old value.
  - Otherwise pc_o<=npc_i and go to S_REQ.
- S_FAULT: terminal. All handshake outputs are 0. The unit leaves S_FAULT only on rst_i.
- npc_valid_i is ignored outside S_WAIT. The bench flags it as a protocol error.
- rvalid_i outside S_RESP is ignored and not consumed (rready_o=0).
- Only one read is outstanding at any time.

## Timing
- Minimum fetch latency: S_REQ is entered at cycle t. With arready_i=1 at t and rvalid_i=1 at t+1, inst_valid_o=1 at t+2.
- Minimum throughput: 1 instruction per 4 cycles (REQ, RESP, OUT, WAIT), with zero-wait memory and the decoder and execute stage responding in the same cycle.
- All state updates happen on the clock edge in which the handshake is sampled high. There are no combinational paths from inputs to outputs except the state decodes.
- rst_i asserted in any state takes priority over all other events at that edge.
  - Any in-flight read is abandoned, and a late rvalid_i is ignored.
  - Next cycle: S_REQ with pc_o=RESET_PC and fetch_cnt_o=0.
- The S_OUT handshake and the fetch_cnt_o increment happen at the same edge. fetch_cnt_o wraps from 32'hFFFF_FFFF to 0.

## Structure
- Shared package (defines) holds:
  - State enum width and encodings.
  - Fault cause codes FETCH_FAULT_NONE/MISALIGN/BUSERR.
  - RESP_OKAY=2'b00.
  - Default RESET_PC.
  - The ysyx_23060251_pc_bus / inst_bus widths, reused for XLEN.
- Single module, no sub-modules; the FSM, PC register and counter are inline.
- The unit replaces pcReg+ifu in top. Its pc_o feeds exu's pc input, and exu's npc drives npc_i, qualified by npc_valid_i.

## Test plan
- Basic fetch: reset, arready_i=1 at once, rvalid_i next cycle with rdata_i=32'h0000_0013 and rresp_i=00 -> araddr_o=32'h8000_0000; inst_valid_o=1 two cycles after S_REQ with inst_o=32'h0000_0013.
- Decoder back-pressure: hold inst_ready_i=0 for 3 cycles -> inst_valid_o=1 and inst_o stable throughout, arvalid_o=0. After the handshake, fetch_cnt_o=1.
- Next-PC redirect: npc_valid_i=1 with npc_i=32'h8000_0004 in S_WAIT -> next cycle arvalid_o=1 with araddr_o=32'h8000_0004. Memory stall: arready_i=0 for 5 cycles -> araddr_o unchanged throughout.
- Misaligned PC: npc_i=32'h8000_0006 -> fault_o=1, fault_cause_o=01, pc_o stays at the old PC, no further arvalid_o until reset.
- Bus error: rresp_i=2'b10 with rvalid_i=1 -> fault_o=1, fault_cause_o=10, inst_valid_o never asserts.
- Reset mid-read: rst_i=1 in S_RESP, then rvalid_i=1 the cycle after reset -> pc_o=32'h8000_0000, arvalid_o=1, rready_o=0, the data is ignored, and fetch_cnt_o=0. Also preload fetch_cnt_o to 32'hFFFF_FFFF and complete one fetch -> fetch_cnt_o=0.
